// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake; define ALU_MUL_EN to build the iterative multiplier
module alu_seq #(
  parameter int DataSize  = 32,
  parameter int ALUopSize = 4,
  parameter int ShAmtSize = $clog2(DataSize)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataSize-1:0]  src1,
  input  logic [DataSize-1:0]  src2,
  input  logic [ALUopSize-1:0] OP,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataSize-1:0]  alu_result,
  output logic                 Overflow,
  output logic                 busy
);

  localparam int MSB = DataSize - 1;
  localparam logic [DataSize-1:0] DW_LIMIT = DataSize'(DataSize);

  localparam logic [ALUopSize-1:0] OP_ADD  = ALUopSize'(4'b0000);
  localparam logic [ALUopSize-1:0] OP_SUB  = ALUopSize'(4'b0001);
  localparam logic [ALUopSize-1:0] OP_AND  = ALUopSize'(4'b0010);
  localparam logic [ALUopSize-1:0] OP_OR   = ALUopSize'(4'b0011);
  localparam logic [ALUopSize-1:0] OP_SLL  = ALUopSize'(4'b0100);
  localparam logic [ALUopSize-1:0] OP_ROTR = ALUopSize'(4'b0101);
  localparam logic [ALUopSize-1:0] OP_ROTL = ALUopSize'(4'b0110);
  localparam logic [ALUopSize-1:0] OP_SRL  = ALUopSize'(4'b0111);
  localparam logic [ALUopSize-1:0] OP_SRA  = ALUopSize'(4'b1000);
  localparam logic [ALUopSize-1:0] OP_XOR  = ALUopSize'(4'b1001);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_armed;

  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_mul_last;
  logic [DataSize-1:0]   w_sum;
  logic [DataSize-1:0]   w_diff;
  logic [ShAmtSize-1:0]  w_amt;
  logic                  w_big_sh;
  logic [2*DataSize-1:0] w_rotr_dbl;
  logic [2*DataSize-1:0] w_rotl_dbl;
  logic [DataSize-1:0]   w_alu_res;
  logic                  w_alu_ovf;

  // Ready is held low until the first clock after reset release.
  assign in_ready  = (r_state == S_IDLE) && r_armed;
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  assign w_sum      = src1 + src2;
  assign w_diff     = src1 - src2;
  assign w_amt      = src2[ShAmtSize-1:0];
  assign w_big_sh   = (src2 >= DW_LIMIT);
  assign w_rotr_dbl = {src1, src1} >> w_amt;
  assign w_rotl_dbl = {src1, src1} << w_amt;

`ifdef ALU_MUL_EN
  localparam logic [ALUopSize-1:0] OP_MUL = ALUopSize'(4'b1010);

  logic [2*DataSize-1:0] r_acc;
  logic [2*DataSize-1:0] r_mcand;
  logic [DataSize-1:0]   r_mplier;
  logic [ShAmtSize-1:0]  r_cnt;
  logic [2*DataSize-1:0] w_acc_next;

  assign w_is_mul   = (OP == OP_MUL);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == ShAmtSize'(DataSize - 1));
  assign busy       = (r_state == S_MUL);

  // Shift-add multiplier: one multiplier bit per cycle, LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= {{DataSize{1'b0}}, src1};
      r_mplier <= src2;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_last = 1'b1;
  assign busy       = 1'b0;
`endif

  // Single-cycle datapath; unknown opcodes (and MUL when not built) yield zero.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (OP)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (src1[MSB] == src2[MSB]) && (w_sum[MSB] != src1[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (src1[MSB] != src2[MSB]) && (w_diff[MSB] != src1[MSB]);
      end
      OP_AND:  w_alu_res = src1 & src2;
      OP_OR:   w_alu_res = src1 | src2;
      OP_XOR:  w_alu_res = src1 ^ src2;
      OP_SLL:  w_alu_res = w_big_sh ? '0 : (src1 << w_amt);
      OP_SRL:  w_alu_res = w_big_sh ? '0 : (src1 >> w_amt);
      OP_SRA:  w_alu_res = w_big_sh ? {DataSize{src1[MSB]}} : DataSize'($signed(src1) >>> w_amt);
      OP_ROTR: w_alu_res = w_rotr_dbl[DataSize-1:0];
      OP_ROTL: w_alu_res = w_rotl_dbl[2*DataSize-1:DataSize];
      default: begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
      end
    endcase
  end

  // State register plus the post-reset ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  // Next-state logic: IDLE -> MUL/DONE on accept, MUL -> DONE after last step, DONE -> IDLE on out_ready.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_last) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result registers: loaded on a single-cycle accept or on the final multiply step, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result <= '0;
      Overflow   <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      alu_result <= w_alu_res;
      Overflow   <= w_alu_ovf;
    end
`ifdef ALU_MUL_EN
    else if ((r_state == S_MUL) && w_mul_last) begin
      alu_result <= w_acc_next[DataSize-1:0];
      Overflow   <= |w_acc_next[2*DataSize-1:DataSize];
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  OP;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;
  logic        Overflow;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq #(.DataSize(32), .ALUopSize(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .OP(OP),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .Overflow(Overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_ready_wait"}, in_ready, 1);
  endtask

  // Issue one single-cycle op, check 1-cycle latency and result, then drain it.
  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eo);
    wait_ready(tag);
    OP = op; src1 = a; src2 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, alu_result, er);
    chk({tag, "_ovf"}, Overflow, eo);
    chk({tag, "_busy"}, busy, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eo);
    int cyc;
    int nbusy;
    wait_ready(tag);
    OP = 4'b1010; src1 = a; src2 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 1;
    nbusy = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) nbusy++;
      step();
      cyc++;
    end
    chk({tag, "_busy_cycles"}, nbusy, 32);
    chk({tag, "_latency"}, cyc, 33);
    chk({tag, "_res"}, alu_result, er);
    chk({tag, "_ovf"}, Overflow, eo);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; OP = '0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_ovf", Overflow, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    run_alu("add_ovf",   4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    run_alu("add_small", 4'b0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);
    run_alu("sub_ovf",   4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    run_alu("sub_neg",   4'b0001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    run_alu("and",       4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    run_alu("or",        4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    run_alu("xor",       4'b1001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    run_alu("rotr33",    4'b0101, 32'h0000_0001, 32'd33,        32'h8000_0000, 1'b0);
    run_alu("rotr32",    4'b0101, 32'h1234_5678, 32'd32,        32'h1234_5678, 1'b0);
    run_alu("rotl1",     4'b0110, 32'h8000_0000, 32'd1,         32'h0000_0001, 1'b0);
    run_alu("rotl8",     4'b0110, 32'h1234_5678, 32'd8,         32'h3456_7812, 1'b0);
    run_alu("sll32",     4'b0100, 32'h0000_0001, 32'd32,        32'h0000_0000, 1'b0);
    run_alu("sll4",      4'b0100, 32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0);
    run_alu("srl4",      4'b0111, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0);
    run_alu("srl40",     4'b0111, 32'h8000_0000, 32'd40,        32'h0000_0000, 1'b0);
    run_alu("sra40",     4'b1000, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 1'b0);
    run_alu("sra4",      4'b1000, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
    run_alu("undef_op",  4'b1111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0);

`ifdef ALU_MUL_EN
    run_mul("mul_big", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_mul("mul_12_13", 32'd12, 32'd13, 32'd156, 1'b0);
`else
    run_alu("mul_disabled", 4'b1010, 32'd12, 32'd13, 32'h0000_0000, 1'b0);
`endif

    // Back-pressure: result held, second op waits for the cycle after the handshake.
    wait_ready("bp");
    OP = 4'b0000; src1 = 32'd3; src2 = 32'd4; in_valid = 1'b1;
    step();
    src1 = 32'd10; src2 = 32'd20;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_res", alu_result, 7);
      chk("bp_hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_after_hs_valid", out_valid, 0);
    chk("bp_after_hs_ready", in_ready, 1);
    chk("bp_after_hs_res", alu_result, 7);
    step();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_res", alu_result, 30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of an operation.
    wait_ready("rst_mid");
`ifdef ALU_MUL_EN
    OP = 4'b1010; src1 = 32'd12; src2 = 32'd13;
`else
    OP = 4'b0000; src1 = 32'd12; src2 = 32'd13;
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_res", alu_result, 0);
    chk("rst_mid_ovf", Overflow, 0);
    chk("rst_mid_ready", in_ready, 0);
    step();
    rst = 1'b0;
    step();
    run_alu("post_rst_add", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
    repeat (3) step();
    chk("post_rst_idle_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational datapath ALU. Adds a valid/ready handshake on input and output, a wider opcode set, and an iterative multi-cycle multiplier.
- Sits between the execute-stage operand muxes and the writeback register. Holds a result until the consumer accepts it.

Parameters:
- DataSize, 32, operand/result width in bits (power of two, >= 8)
- ALUopSize, 4, opcode width
- ShAmtSize, $clog2(DataSize), number of src2 LSBs used as rotate amount

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block can accept an operation
- src1  input  DataSize  operand A
- src2  input  DataSize  operand B / shift amount
- OP  input  ALUopSize  opcode
- out_valid  output  1  alu_result/Overflow valid
- out_ready  input  1  consumer accepts result
- alu_result  output  DataSize  registered result
- Overflow  output  1  registered overflow flag
- busy  output  1  multiplier iterating

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; alu_result=0, Overflow=0, out_valid=0, busy=0, iteration counter=0.
  - in_ready becomes 1 on the first clk edge after rst deasserts.
  - rst mid-multiply aborts the operation; no result is produced.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE); busy = (state==MUL); out_valid = (state==DONE).
- IDLE, on accept (in_valid && in_ready):
  - Non-MUL op: result and Overflow are computed combinationally and registered; go to DONE. Latency is 1 cycle from accept to out_valid.
  - MUL: latch src1 and src2, clear the accumulator, set counter=0, go to MUL.
- MUL: one shift-add step per cycle, LSB-first on src2.
  - After exactly DataSize cycles, go to DONE. MUL latency is DataSize+1 cycles from accept.
  - in_valid is ignored while in MUL.
- DONE: alu_result/Overflow held stable while out_ready=0.
  - On out_ready=1: go to IDLE.
  - A new op can be accepted no earlier than the cycle after the handshake (no same-cycle pass-through). Peak throughput is 1 op per 2 cycles.
- Opcodes (4-bit):
  - 0000 ADD: Overflow = signed overflow (operand signs equal, result sign differs).
  - 0001 SUB: Overflow when src1 sign != src2 sign and result sign != src1 sign.
  - 0010 AND, 0011 OR, 1001 XOR: Overflow=0.
  - 0100 SLL, 0111 SRL: full src2 is the shift amount; src2 >= DataSize gives 0.
  - 1000 SRA: src2 >= DataSize gives all sign bits.
  - 0101 ROTR, 0110 ROTL: amount = src2[ShAmtSize-1:0] (modulo DataSize).
  - 1010 MUL: unsigned; alu_result = low DataSize bits of the 2*DataSize product; Overflow = |high half.
  - All others: alu_result=0, Overflow=0, 1-cycle latency.
  - Overflow=0 for every shift and rotate op.
- Width rules: all add/sub/shift arithmetic is DataSize bits, with the carry discarded. The MUL accumulator is 2*DataSize bits.

Optional Feature:
- Macro ALU_MUL_EN.
  - Defined: MUL state, accumulator and counter are present; behaviour as above.
  - Undefined: no multiplier logic and MUL state unreachable. Opcode 1010 behaves as an undefined opcode (result 0, Overflow 0, 1-cycle latency); busy is tied to 0.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid one cycle after accept, alu_result=0x80000000, Overflow=1.
- SUB 0x80000000 - 0x00000001 -> 0x7FFFFFFF, Overflow=1. AND/OR/XOR of 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00.
- ROTR 0x00000001 by 33 -> 0x80000000. ROTL 0x80000000 by 1 -> 0x00000001. SLL 0x1 by 32 -> 0. SRA 0x80000000 by 40 -> 0xFFFFFFFF.
- MUL 0x00010000 * 0x00010000 -> busy for 32 cycles, out_valid at cycle 33, alu_result=0, Overflow=1. MUL 12*13 -> 156, Overflow=0.
- Back-pressure: hold out_ready=0 for 5 cycles after ADD 3+4 -> result 7 stable, in_ready=0 throughout. A second in_valid is not accepted until the cycle after out_ready=1.
- Assert rst 10 cycles into a MUL -> all outputs 0 immediately. After release, a new ADD 1+1 returns 2 with no stale MUL result.
- With ALU_MUL_EN undefined: OP=1010 -> result 0, 1-cycle latency, busy never 1.
